pc_unit: RTL and testbench



---
 rtl/pc_unit.sv | 197 +++++++++++++++++++
 tb/tb_pc_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit
//
// Owns the instruction fetch address. It generates the sequential next PC,
// applies trap vectoring and branch/jump redirects by fixed priority, turns
// misaligned redirect targets into a trap-vector load plus a one-cycle flag,
// supports halt/resume, and presents the PC to instruction memory through a
// valid/ready handshake.
//
// Parameters:
//   XLEN         width of PC and all address ports
//   RESET_VEC    PC loaded on reset (truncated/zero-extended to XLEN)
//   TRAP_VEC     PC loaded on trap or misaligned redirect (same sizing)
//   INSTR_BYTES  sequential increment, 2 or 4
//
// Ports:
//   CLK             in   clock, all state changes on the rising edge
//   RST             in   synchronous active-high reset
//   fetch_ready     in   instruction memory accepts PC this cycle
//   redirect_en     in   branch/jump taken, load redirect_pc
//   redirect_pc     in   redirect target (XLEN)
//   trap_en         in   exception/interrupt, load TRAP_VEC
//   halt_req        in   request halt (debug / wfi)
//   resume          in   leave HALT
//   PC              out  current fetch address (registered, XLEN)
//   PCPlus          out  PC + INSTR_BYTES, combinational, wraps mod 2^XLEN
//   fetch_valid     out  PC is a live fetch request (state RUN)
//   misalign        out  one-cycle pulse after a misaligned redirect
//   halted          out  unit is in HALT
//
// Optional feature, enabled by defining PC_UNIT_PERF_EN:
//   fetch_count     out  32-bit count of accepted fetches (valid && ready)
//   redirect_count  out  16-bit count of trap/redirect PC loads
//   Both clear on RST and wrap silently. Without the macro the ports and
//   counters do not exist and all other behaviour is unchanged.
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int          INSTR_BYTES = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            fetch_ready,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_en,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus,
    output logic            fetch_valid,
    output logic            misalign,
    output logic            halted
`ifdef PC_UNIT_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [15:0]     redirect_count
`endif
);

    // Low address bits that must be zero in a legal target. Only 2- and
    // 4-byte instructions are supported, so this is 1 or 2.
    localparam int ALIGN = (INSTR_BYTES == 2) ? 1 : 2;

    // Vectors are given as 32-bit values; size them to the PC width once.
    localparam logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VEC);
    localparam logic [XLEN-1:0] TRAP_PC  = XLEN'(TRAP_VEC);
    localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    // A redirect target is illegal if any of its low ALIGN bits are set.
    logic target_misaligned;
    assign target_misaligned = (redirect_pc[ALIGN-1:0] != '0);

    // PC address of a redirect after the alignment check: either the
    // target itself or the trap vector.
    logic [XLEN-1:0] redirect_dest;
    assign redirect_dest = target_misaligned ? TRAP_PC : redirect_pc;

    // Sequential successor; the adder drops the carry, so the top of the
    // address space wraps to zero without any flag.
    assign PCPlus = PC + STEP;

`ifdef PC_UNIT_PERF_EN
    // A trap or redirect reloads the PC in every state except BOOT, which
    // ignores its inputs.
    logic pc_reload;
    assign pc_reload = (state != BOOT) && (trap_en || redirect_en);
`endif

    // The FSM, the PC and the registered outputs share one clocked block so
    // fetch_valid/halted always change on the same edge as the state.
    // NOTE: every register here uses non-blocking assignment so that all
    // right-hand sides read the pre-edge values (PC, PCPlus, state)
    // regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: reset is synchronous and covers every register; there is
            // no memory array here, so nothing is left unreset and a reset
            // during a stall or halt leaves no residue.
            state       <= BOOT;
            PC          <= RESET_PC;
            misalign    <= 1'b0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            // misalign is a single-cycle pulse; only a misaligned redirect
            // in this cycle raises it for the next one.
            misalign <= 1'b0;

            unique case (state)
                // Exactly one cycle, inputs ignored.
                BOOT: begin
                    state       <= RUN;
                    fetch_valid <= 1'b1;
                    halted      <= 1'b0;
                end

                RUN: begin
                    if (trap_en) begin
                        PC <= TRAP_PC;
                    end else if (redirect_en) begin
                        // Abandons any pending fetch; the memory side must
                        // tolerate the request changing under it.
                        PC       <= redirect_dest;
                        misalign <= target_misaligned;
                    end else if (halt_req) begin
                        state       <= HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else if (fetch_ready) begin
                        PC <= PCPlus;
                    end
                    // Otherwise stall: PC holds while the request is pending.
                end

                HALT: begin
                    // fetch_ready and halt_req have no effect here.
                    if (trap_en) begin
                        PC          <= TRAP_PC;
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                        halted      <= 1'b0;
                    end else begin
                        // Debug PC write: same alignment rule as in RUN, but
                        // by itself it does not leave HALT.
                        if (redirect_en) begin
                            PC       <= redirect_dest;
                            misalign <= target_misaligned;
                        end
                        // resume together with a redirect fetches the new PC
                        // first, because both land on the same edge.
                        if (resume) begin
                            state       <= RUN;
                            fetch_valid <= 1'b1;
                            halted      <= 1'b0;
                        end
                    end
                end

                // Unreachable encoding: restart through BOOT.
                default: begin
                    state       <= BOOT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_UNIT_PERF_EN
    // Performance counters; both wrap silently at their width.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (fetch_valid && fetch_ready) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (pc_reload) begin
                redirect_count <= redirect_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit
//
// Three instances share one set of inputs:
//   dut    XLEN=32, INSTR_BYTES=4  (main table-driven run)
//   dut2   XLEN=32, INSTR_BYTES=2  (alignment rule for 2-byte instructions)
//   dut8   XLEN=8,  INSTR_BYTES=4  (address wrap, truncated vectors)
// With PC_UNIT_PERF_EN defined the counters of dut are checked as well.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic        ren;
    logic [31:0] rpc;
    logic        trap;
    logic        hreq;
    logic        res;

    logic [31:0] pc,  pcplus;
    logic        valid, mis, halted;
    logic [31:0] pc2, pcplus2;
    logic        valid2, mis2, halted2;
    logic [7:0]  pc8, pcplus8;
    logic        valid8, mis8, halted8;
`ifdef PC_UNIT_PERF_EN
    logic [31:0] fcnt;
    logic [15:0] rcnt;
    logic [31:0] fcnt2, fcnt8;
    logic [15:0] rcnt2, rcnt8;
`endif

    always #5 clk = ~clk;

    pc_unit #(.XLEN(32), .INSTR_BYTES(4)) dut (
        .CLK(clk), .RST(rst), .fetch_ready(ready), .redirect_en(ren),
        .redirect_pc(rpc), .trap_en(trap), .halt_req(hreq), .resume(res),
        .PC(pc), .PCPlus(pcplus), .fetch_valid(valid), .misalign(mis),
        .halted(halted)
`ifdef PC_UNIT_PERF_EN
        , .fetch_count(fcnt), .redirect_count(rcnt)
`endif
    );

    pc_unit #(.XLEN(32), .INSTR_BYTES(2)) dut2 (
        .CLK(clk), .RST(rst), .fetch_ready(ready), .redirect_en(ren),
        .redirect_pc(rpc), .trap_en(trap), .halt_req(hreq), .resume(res),
        .PC(pc2), .PCPlus(pcplus2), .fetch_valid(valid2), .misalign(mis2),
        .halted(halted2)
`ifdef PC_UNIT_PERF_EN
        , .fetch_count(fcnt2), .redirect_count(rcnt2)
`endif
    );

    pc_unit #(.XLEN(8), .INSTR_BYTES(4)) dut8 (
        .CLK(clk), .RST(rst), .fetch_ready(ready), .redirect_en(ren),
        .redirect_pc(rpc[7:0]), .trap_en(trap), .halt_req(hreq), .resume(res),
        .PC(pc8), .PCPlus(pcplus8), .fetch_valid(valid8), .misalign(mis8),
        .halted(halted8)
`ifdef PC_UNIT_PERF_EN
        , .fetch_count(fcnt8), .redirect_count(rcnt8)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, clock once, sample 1 time unit after edge.
    task automatic step(input logic r, input logic rdy, input logic re,
                        input logic [31:0] rp, input logic tr,
                        input logic hr, input logic rs);
        rst   = r;
        ready = rdy;
        ren   = re;
        rpc   = rp;
        trap  = tr;
        hreq  = hr;
        res   = rs;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, rdy, ren;
        logic [31:0] rpc;
        logic        trap, hreq, res;
        logic [31:0] pc;
        logic        valid, mis, halt;
    } vec_t;

    vec_t vecs[$];

    // Watchdog: the run is short; anything this long is a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 rst rdy ren rpc           trp hrq res  pc            v  m  h
        vecs.push_back('{1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0}); // BOOT next
        vecs.push_back('{0, 1, 0, 32'h0,        1, 0, 0, 32'h0,        1, 0, 0}); // BOOT ignores trap
        vecs.push_back('{0, 1, 0, 32'h0,        0, 0, 0, 32'h4,        1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 0, 0, 32'h8,        1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 0, 0, 32'hC,        1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 0, 0, 32'h10,       1, 0, 0});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h10,       1, 0, 0}); // stall x3
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h10,       1, 0, 0});
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h10,       1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 0, 0, 32'h14,       1, 0, 0});
        vecs.push_back('{0, 1, 1, 32'h400,      1, 0, 0, 32'h100,      1, 0, 0}); // trap beats redirect
        vecs.push_back('{0, 0, 1, 32'h400,      0, 0, 0, 32'h400,      1, 0, 0}); // redirect, not ready
        vecs.push_back('{0, 1, 1, 32'h200,      0, 1, 0, 32'h200,      1, 0, 0}); // redirect beats halt/ready
        vecs.push_back('{0, 1, 1, 32'h402,      0, 0, 0, 32'h100,      1, 1, 0}); // misaligned
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h100,      1, 0, 0}); // pulse is one cycle
        vecs.push_back('{0, 0, 1, 32'h20,       0, 0, 0, 32'h20,       1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 0, 32'h20,       0, 0, 1}); // halt beats ready
        vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 0, 32'h20,       0, 0, 1}); // ready ignored in HALT
        vecs.push_back('{0, 0, 1, 32'h80,       0, 0, 0, 32'h80,       0, 0, 1}); // debug PC write
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 32'h80,       1, 0, 0}); // resume
        vecs.push_back('{0, 1, 0, 32'h0,        0, 0, 0, 32'h84,       1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h0,        0, 1, 0, 32'h84,       0, 0, 1});
        vecs.push_back('{0, 0, 1, 32'h81,       0, 0, 0, 32'h100,      0, 1, 1}); // misaligned in HALT
        vecs.push_back('{0, 0, 1, 32'h300,      0, 0, 1, 32'h300,      1, 0, 0}); // resume + redirect
        vecs.push_back('{0, 0, 0, 32'h0,        0, 1, 0, 32'h300,      0, 0, 1});
        vecs.push_back('{0, 0, 0, 32'h0,        1, 0, 0, 32'h100,      1, 0, 0}); // trap leaves HALT
        vecs.push_back('{0, 0, 0, 32'h0,        0, 1, 0, 32'h100,      0, 0, 1});
        vecs.push_back('{1, 1, 1, 32'h40,       1, 0, 1, 32'h0,        0, 0, 0}); // RST in HALT
        vecs.push_back('{0, 0, 1, 32'h6,        0, 0, 0, 32'h0,        1, 0, 0}); // BOOT ignores redirect
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0}); // stalled
        vecs.push_back('{1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0}); // RST mid-stall
        vecs.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 0, 0});
        vecs.push_back('{0, 0, 1, 32'h6,        0, 0, 0, 32'h100,      1, 1, 0});
        vecs.push_back('{1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0}); // RST clears pulse

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].rdy, vecs[i].ren, vecs[i].rpc,
                 vecs[i].trap, vecs[i].hreq, vecs[i].res);
            check($sformatf("vec%0d PC", i),          pc,     vecs[i].pc);
            check($sformatf("vec%0d PCPlus", i),      pcplus, vecs[i].pc + 32'd4);
            check($sformatf("vec%0d fetch_valid", i), 32'(valid),  32'(vecs[i].valid));
            check($sformatf("vec%0d misalign", i),    32'(mis),    32'(vecs[i].mis));
            check($sformatf("vec%0d halted", i),      32'(halted), 32'(vecs[i].halt));
        end

        // 2-byte instructions: 0x402 is legal, 0x403 is not.
        step(1, 0, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0, 0);
        step(0, 0, 1, 32'h402, 0, 0, 0);
        check("ib2 legal PC",       pc2,        32'h402);
        check("ib2 legal misalign", 32'(mis2),  32'd0);
        check("ib4 same PC",        pc,         32'h100);
        check("ib4 same misalign",  32'(mis),   32'd1);
        step(0, 0, 1, 32'h403, 0, 0, 0);
        check("ib2 odd PC",         pc2,        32'h100);
        check("ib2 odd misalign",   32'(mis2),  32'd1);
        step(0, 1, 0, 32'h0, 0, 0, 0);
        check("ib2 step PC",        pc2,        32'h102);
        check("ib2 PCPlus",         pcplus2,    32'h104);
        check("ib2 pulse gone",     32'(mis2),  32'd0);

        // XLEN=8: wrap from 0xFC, and the trap vector truncates to 0x00.
        step(0, 0, 1, 32'hFC, 0, 0, 0);
        check("x8 PC FC",           32'(pc8),     32'hFC);
        check("x8 PCPlus wraps",    32'(pcplus8), 32'h00);
        step(0, 1, 0, 32'h0, 0, 0, 0);
        check("x8 PC wrapped",      32'(pc8),     32'h00);
        check("x8 no flag",         32'(mis8),    32'd0);
        check("x8 still valid",     32'(valid8),  32'd1);
        step(0, 1, 0, 32'h0, 0, 0, 0);
        check("x8 PC 04",           32'(pc8),     32'h04);
        step(0, 0, 0, 32'h0, 1, 0, 0);
        check("x8 trap vec",        32'(pc8),     32'h00);

`ifdef PC_UNIT_PERF_EN
        // 5 accepted fetches, then 2 PC reloads with ready low.
        step(1, 1, 0, 32'h0, 0, 0, 0);
        check("perf fetch after rst",    fcnt,       32'd0);
        check("perf redirect after rst", 32'(rcnt),  32'd0);
        step(0, 1, 0, 32'h0, 0, 0, 0);  // BOOT: not a fetch
        for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h0, 0, 0, 0);
        step(0, 0, 1, 32'h40, 0, 0, 0);
        step(0, 0, 0, 32'h0, 1, 0, 0);
        check("perf fetch_count",    fcnt,      32'd5);
        check("perf redirect_count", 32'(rcnt), 32'd2);
        step(1, 0, 0, 32'h0, 0, 0, 0);
        check("perf fetch clear",    fcnt,      32'd0);
        check("perf redirect clear", 32'(rcnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
